fifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller for the asynchronous FIFO. Sits directly upstream of the FIFO memory. It drives the memory's write address and full flag, and generates the Gray-coded write pointer sent to the read domain. It also synchronizes the read domain's Gray pointer into the write clock domain and derives full, almost-full, fill level and a sticky overflow flag from it.

---
 rtl/fifo_wr_ctrl.sv | 87 ++++++++
 tb/tb_fifo_wr_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller for an asynchronous FIFO: binary/Gray write pointer,
// read-pointer synchronizer, and registered full / almost-full / level / sticky overflow.
module fifo_wr_ctrl #(
   parameter int ADDRESS     = 3,
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int AFULL_LEVEL = 6
) (
   input  logic               W_CLK,
   input  logic               W_RST,
   input  logic               W_INC,
   input  logic [ADDRESS:0]   R_PTR,
   input  logic               OVF_CLR,
   output logic [ADDRESS-1:0] W_ADDR,
   output logic [ADDRESS:0]   W_PTR,
   output logic               W_FULL,
   output logic               W_AFULL,
   output logic [ADDRESS:0]   W_LEVEL,
   output logic               W_OVF
);

   // Full when the Gray pointers differ only in their two MSBs.
   localparam logic [ADDRESS:0] FULL_MASK = {2'b11, {(ADDRESS-1){1'b0}}};
   localparam int               AFULL_CLAMP = (AFULL_LEVEL > DEPTH) ? DEPTH : AFULL_LEVEL;
   localparam logic [ADDRESS:0] AFULL_THR = (ADDRESS+1)'(AFULL_CLAMP);

   logic [ADDRESS:0] wbin;
   logic [ADDRESS:0] wbin_next;
   logic [ADDRESS:0] wgray_next;
   logic [ADDRESS:0] rq;
   logic [ADDRESS:0] rbin;
   logic [ADDRESS:0] level_next;
   logic [ADDRESS:0] sync_q [SYNC_STAGES];
   logic             accepted;
   logic             full_next;
   logic             afull_next;

   assign accepted   = W_INC & ~W_FULL;
   assign wbin_next  = wbin + {{ADDRESS{1'b0}}, accepted};
   assign wgray_next = wbin_next ^ (wbin_next >> 1);
   assign rq         = sync_q[SYNC_STAGES-1];

   always_comb begin
      logic acc;
      rbin = '0;
      acc  = 1'b0;
      for (int i = ADDRESS; i >= 0; i--) begin
         acc     = acc ^ rq[i];
         rbin[i] = acc;
      end
   end

   assign level_next = wbin_next - rbin;
   assign full_next  = (wgray_next == (rq ^ FULL_MASK));
   assign afull_next = (level_next >= AFULL_THR);

   always_ff @(posedge W_CLK or posedge W_RST) begin
      if (W_RST) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= R_PTR;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   always_ff @(posedge W_CLK or posedge W_RST) begin
      if (W_RST) begin
         wbin    <= '0;
         W_ADDR  <= '0;
         W_PTR   <= '0;
         W_FULL  <= 1'b0;
         W_AFULL <= 1'b0;
         W_LEVEL <= '0;
         W_OVF   <= 1'b0;
      end else begin
         wbin    <= wbin_next;
         W_ADDR  <= wbin_next[ADDRESS-1:0];
         W_PTR   <= wgray_next;
         W_FULL  <= full_next;
         W_AFULL <= afull_next;
         W_LEVEL <= level_next;
         // A blocked write in the same cycle as a clear keeps the flag set.
         W_OVF   <= (W_INC & W_FULL) | (W_OVF & ~OVF_CLR);
      end
   end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: an occupancy-count model predicts each edge's outputs,
// a monitor pops and compares them one cycle later.
module tb_fifo_wr_ctrl;
   localparam int A  = 3;
   localparam int D  = 8;
   localparam int S  = 2;
   localparam int AF = 6;

   logic         W_CLK = 1'b0;
   logic         W_RST;
   logic         W_INC;
   logic [A:0]   R_PTR;
   logic         OVF_CLR;
   logic [A-1:0] W_ADDR;
   logic [A:0]   W_PTR;
   logic         W_FULL;
   logic         W_AFULL;
   logic [A:0]   W_LEVEL;
   logic         W_OVF;

   fifo_wr_ctrl #(.ADDRESS(A), .DEPTH(D), .SYNC_STAGES(S), .AFULL_LEVEL(AF)) dut (
      .W_CLK(W_CLK), .W_RST(W_RST), .W_INC(W_INC), .R_PTR(R_PTR), .OVF_CLR(OVF_CLR),
      .W_ADDR(W_ADDR), .W_PTR(W_PTR), .W_FULL(W_FULL), .W_AFULL(W_AFULL),
      .W_LEVEL(W_LEVEL), .W_OVF(W_OVF)
   );

   always #5 W_CLK = ~W_CLK;

   typedef struct {
      int addr;
      int ptr;
      int full;
      int afull;
      int level;
      int ovf;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   // Model state: unbounded counts of writes accepted and reads completed.
   int   wcount, rcount, e;
   bit   full_m, ovf_m;
   int   hist[$];

   function automatic int gray(input int v);
      return v ^ (v >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      wcount = 0; rcount = 0; e = 0; full_m = 0; ovf_m = 0;
      hist.delete();
   endtask

   // Called at a falling edge: drive inputs, predict the next rising edge, move on.
   task automatic step(input bit inc, input bit clr);
      int rs, lvl;
      bit nov;
      W_INC   = inc;
      OVF_CLR = clr;
      R_PTR   = 4'(gray(rcount % 16));
      hist.push_back(rcount);
      rs  = (e >= S) ? hist[e-S] : 0;
      nov = (inc && full_m) ? 1'b1 : (clr ? 1'b0 : ovf_m);
      if (inc && !full_m) wcount++;
      lvl    = wcount - rs;
      full_m = (lvl == D);
      ovf_m  = nov;
      e++;
      q.push_back('{wcount % D, gray(wcount % (2*D)), int'(full_m), int'(lvl >= AF), lvl, int'(ovf_m)});
      @(negedge W_CLK);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_addr"},  int'(W_ADDR), 0);
      chk({tag, "_ptr"},   int'(W_PTR), 0);
      chk({tag, "_full"},  int'(W_FULL), 0);
      chk({tag, "_afull"}, int'(W_AFULL), 0);
      chk({tag, "_level"}, int'(W_LEVEL), 0);
      chk({tag, "_ovf"},   int'(W_OVF), 0);
   endtask

   // Called at a falling edge: assert reset between edges, expect outputs cleared at once.
   task automatic async_reset();
      #2 W_RST = 1'b1;
      #1 check_zero("async_rst");
      @(posedge W_CLK);
      @(negedge W_CLK);
      W_RST = 1'b0; W_INC = 1'b0; OVF_CLR = 1'b0;
      model_reset();
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge W_CLK);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            chk("addr",  int'(W_ADDR),  x.addr);
            chk("ptr",   int'(W_PTR),   x.ptr);
            chk("full",  int'(W_FULL),  x.full);
            chk("afull", int'(W_AFULL), x.afull);
            chk("level", int'(W_LEVEL), x.level);
            chk("ovf",   int'(W_OVF),   x.ovf);
         end
      end
   end

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      W_RST = 1'b1; W_INC = 1'b0; OVF_CLR = 1'b0; R_PTR = '0;
      model_reset();
      #1 check_zero("reset");
      @(negedge W_CLK);
      W_RST = 1'b0;

      // Eight writes into an empty FIFO, then two blocked writes.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      // Clear alone, then clear colliding with a blocked write.
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);

      // Three reads become visible after the synchronizer.
      rcount = 3;
      for (int i = 0; i < S + 2; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);

      // Continuous writes with the reader keeping up; pointer wraps.
      for (int i = 0; i < 20; i++) begin
         rcount = wcount;
         step(1'b1, 1'b0);
      end

      // Fill up, overflow, drain to level 5, then reset mid-burst.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      rcount = wcount - 5;
      for (int i = 0; i < S + 1; i++) step(1'b0, 1'b0);
      W_INC = 1'b1;
      async_reset();
      step(1'b1, 1'b0);

      // Level 7, then final write together with one read.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      rcount = 1;
      step(1'b1, 1'b0);
      for (int i = 0; i < S + 2; i++) step(1'b0, 1'b0);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         int adv;
         adv = $urandom_range(0, 2);
         if (rcount + adv > wcount) adv = wcount - rcount;
         rcount += adv;
         step($urandom_range(0, 99) < 65, $urandom_range(0, 9) == 0);
      end
      step(1'b0, 1'b0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge W_CLK);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
